// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: fetches words over a req/ack memory handshake,
// holds up to DEPTH {pc, word} entries and presents the head to the core.
// A redirect flushes the buffer and restarts fetch at the new PC. A request
// that is still outstanding is kept asserted until its ack, and that ack's
// data is thrown away.
module inst_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     inst_valid,
  output logic [31:0]              inst_out,
  output logic [31:0]              inst_pc,
  input  logic                     inst_take,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   drop_addr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   word_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_pc_aligned;

  // A redirect overrides everything: no push of the returning word and no pop
  assign push                = (state == ST_REQ) && mem_ack && !redirect;
  assign pop                 = inst_take && (count != '0) && !redirect;
  assign count_next          = count + CW'(push) - CW'(pop);
  assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};

  assign mem_req    = (state != ST_IDLE);
  assign mem_addr   = (state == ST_DROP) ? drop_addr : fetch_pc;
  assign inst_valid = (count != '0);
  assign inst_out   = word_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];
  assign fill_level = count;

  // Next-state selection for the fetch sequencer
  always_comb begin
    state_next = state;
    if (redirect) begin
      case (state)
        ST_IDLE: state_next = ST_REQ;
        // An ack landing together with the redirect finishes the old
        // handshake, so fetch at the new PC can start straight away
        ST_REQ:  state_next = mem_ack ? ST_REQ : ST_DROP;
        ST_DROP: state_next = mem_ack ? ST_REQ : ST_DROP;
        default: state_next = ST_REQ;
      endcase
    end else begin
      case (state)
        ST_IDLE: if (count < CW'(DEPTH)) state_next = ST_REQ;
        ST_REQ:  if (mem_ack) state_next = (count_next < CW'(DEPTH)) ? ST_REQ : ST_IDLE;
        ST_DROP: if (mem_ack) state_next = ST_REQ;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Fetch address: jumps on redirect, otherwise advances per accepted word
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= redirect_pc_aligned;
    else if (push)     fetch_pc <= fetch_pc + 32'd4;
  end

  // Remember the address of a request abandoned mid-handshake so it stays stable
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          drop_addr <= RESET_PC;
    else if ((state == ST_REQ) && redirect && !mem_ack) drop_addr <= fetch_pc;
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        word_mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= fetch_pc;
        word_mem[wr_ptr] <= mem_rdata;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Testbench for inst_prefetch_buffer: a cycle table drives redirect/ack/take
// and lists the expected handshake outputs; delivered words go into a
// scoreboard queue and are compared against the head entry.
module tb_inst_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_take;
  logic [2:0]  fill_level;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_pc[$];
  logic [31:0] exp_word[$];

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        ack;
    logic        take;
    logic        live;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [2:0]  e_fill;
  } vec_t;

  vec_t vecs[$];

  inst_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_take   (inst_take),
    .fill_level  (fill_level)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic ack,
                              input logic take, input logic live, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [2:0] e_fill);
    vec_t v;
    v.rd = rd; v.rpc = rpc; v.ack = ack; v.take = take; v.live = live;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_fill = e_fill;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the outputs visible in this cycle against the row and scoreboard
  task automatic checkOutput(input vec_t v, input int row);
    string tag;
    tag = $sformatf("row%0d", row);
    check32({tag, " mem_req"}, {31'd0, mem_req}, {31'd0, v.e_req});
    if (v.e_req) check32({tag, " mem_addr"}, mem_addr, v.e_addr);
    check32({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, v.e_valid});
    check32({tag, " fill_level"}, {29'd0, fill_level}, {29'd0, v.e_fill});
    if (v.e_valid) begin
      if (exp_pc.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s scoreboard: DUT shows pc 0x%08h but no entry expected", tag, inst_pc);
      end else begin
        check32({tag, " inst_pc"}, inst_pc, exp_pc[0]);
        check32({tag, " inst_out"}, inst_out, exp_word[0]);
      end
    end
  endtask

  // Drive this row's inputs for the coming edge and update the scoreboard
  task automatic applyStimulus(input vec_t v);
    redirect    = v.rd;
    redirect_pc = v.rpc;
    mem_ack     = v.ack;
    inst_take   = v.take;
    mem_rdata   = mem_word(v.e_addr);
    if (v.rd) begin
      exp_pc.delete();
      exp_word.delete();
    end else begin
      if (v.take && v.e_valid && exp_pc.size() != 0) begin
        void'(exp_pc.pop_front());
        void'(exp_word.pop_front());
      end
      if (v.ack && v.live) begin
        exp_pc.push_back(v.e_addr);
        exp_word.push_back(mem_word(v.e_addr));
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    inst_take   = 1'b0;

    //           rd   rpc            ack take live req  addr           valid fill
    // Fill from reset with ack held high, then IDLE while full
    vecs.push_back(mk(0, 32'h0,          1, 0, 0, 0, 32'h0,          0, 3'd0));
    vecs.push_back(mk(0, 32'h0,          1, 0, 1, 1, 32'h0,          0, 3'd0));
    vecs.push_back(mk(0, 32'h0,          1, 0, 1, 1, 32'h4,          1, 3'd1));
    vecs.push_back(mk(0, 32'h0,          1, 0, 1, 1, 32'h8,          1, 3'd2));
    vecs.push_back(mk(0, 32'h0,          1, 0, 1, 1, 32'hC,          1, 3'd3));
    vecs.push_back(mk(0, 32'h0,          1, 0, 0, 0, 32'h0,          1, 3'd4));
    // Single take from full; request resumes a cycle later at 0x10
    vecs.push_back(mk(0, 32'h0,          1, 1, 0, 0, 32'h0,          1, 3'd4));
    vecs.push_back(mk(0, 32'h0,          0, 0, 0, 0, 32'h0,          1, 3'd3));
    vecs.push_back(mk(0, 32'h0,          0, 1, 0, 1, 32'h10,         1, 3'd3));
    // Take and ack together at fill_level 2
    vecs.push_back(mk(0, 32'h0,          1, 1, 1, 1, 32'h10,         1, 3'd2));
    vecs.push_back(mk(0, 32'h0,          0, 0, 0, 1, 32'h14,         1, 3'd2));
    // Redirect while a slow request is pending: held address, word dropped
    vecs.push_back(mk(1, 32'h100,        0, 0, 0, 1, 32'h14,         1, 3'd2));
    vecs.push_back(mk(0, 32'h0,          0, 0, 0, 1, 32'h14,         0, 3'd0));
    vecs.push_back(mk(0, 32'h0,          1, 0, 0, 1, 32'h14,         0, 3'd0));
    vecs.push_back(mk(0, 32'h0,          1, 0, 1, 1, 32'h100,        0, 3'd0));
    // Redirect coinciding with ack, unaligned target; take ignored
    vecs.push_back(mk(1, 32'h203,        1, 1, 0, 1, 32'h104,        1, 3'd1));
    // Redirect with no ack, then a second redirect while dropping
    vecs.push_back(mk(1, 32'h400,        0, 0, 0, 1, 32'h200,        0, 3'd0));
    vecs.push_back(mk(1, 32'hFFFF_FFFE,  0, 0, 0, 1, 32'h200,        0, 3'd0));
    vecs.push_back(mk(0, 32'h0,          1, 0, 0, 1, 32'h200,        0, 3'd0));
    // Address wrap at the top of memory
    vecs.push_back(mk(0, 32'h0,          1, 0, 1, 1, 32'hFFFF_FFFC,  0, 3'd0));
    vecs.push_back(mk(0, 32'h0,          1, 0, 1, 1, 32'h0,          1, 3'd1));
    // Drain, including a take on an empty buffer
    vecs.push_back(mk(0, 32'h0,          0, 1, 0, 1, 32'h4,          1, 3'd2));
    vecs.push_back(mk(0, 32'h0,          0, 1, 0, 1, 32'h4,          1, 3'd1));
    vecs.push_back(mk(0, 32'h0,          0, 1, 0, 1, 32'h4,          0, 3'd0));
    vecs.push_back(mk(0, 32'h0,          0, 0, 0, 1, 32'h4,          0, 3'd0));

    repeat (3) @(negedge clk);
    check32("reset mem_req",    {31'd0, mem_req},    32'd0);
    check32("reset mem_addr",   mem_addr,            32'h0);
    check32("reset inst_valid", {31'd0, inst_valid}, 32'd0);
    check32("reset inst_out",   inst_out,            32'h0);
    check32("reset inst_pc",    inst_pc,             32'h0);
    check32("reset fill_level", {29'd0, fill_level}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      checkOutput(vecs[i], i);
      applyStimulus(vecs[i]);
    end

    // Reset in the middle of an active handshake, ack still high afterwards
    @(negedge clk);
    mem_ack   = 1'b1;
    inst_take = 1'b0;
    redirect  = 1'b0;
    reset     = 1'b1;
    #1;
    check32("midreset mem_req",    {31'd0, mem_req},    32'd0);
    check32("midreset mem_addr",   mem_addr,            32'h0);
    check32("midreset fill_level", {29'd0, fill_level}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check32("postreset mem_req",    {31'd0, mem_req},    32'd1);
    check32("postreset mem_addr",   mem_addr,            32'h0);
    check32("postreset fill_level", {29'd0, fill_level}, 32'd0);
    mem_ack = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
